exe_stage_unit: RTL and testbench
=================================

Name: exe_stage_unit

Overview:
- Execute stage of the 5-stage ARM-subset pipeline. It sits directly downstream of the ID stage register and consumes its registered outputs.
- Datapath: generates the second operand (Val2), runs the ALU, updates the NZCV status register, and computes the branch target.
- Registers its results into the EXE/MEM pipeline register for the memory stage.

Parameters:
- DATA_W, 32, datapath width (fixed at 32; used for readability only).
- REG_ADDR_W, 4, register-file address width of Dest.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  memory-stall hold for EXE/MEM register and status register
- wb_enable  in  1  writeback enable from ID reg
- mem_read_enable  in  1  load
- mem_write_enable  in  1  store
- branch_enable  in  1  branch
- S  in  1  update flags
- exec_cmd  in  4  ALU command
- PC  in  32  PC+4 of instruction
- Val_Rn  in  32  operand 1
- Val_Rm  in  32  register operand 2
- immidiate  in  1  I bit
- Shift_operand  in  12  shifter operand
- Signed_immidiate_24  in  24  branch offset
- Dest  in  4  destination register
- branch_taken  out  1  combinational, equals branch_enable
- branch_address  out  32  combinational PC + (sext(imm24) << 2)
- status_out  out  4  status register {N,Z,C,V}, feeds ID Status input
- wb_en_out  out  1  registered
- mem_r_en_out  out  1  registered
- mem_w_en_out  out  1  registered
- alu_result  out  32  registered
- val_rm_out  out  32  registered store data
- dest_out  out  4  registered

Behaviour:
- Reset (rst=1 at posedge): all registered outputs and status_out go to 0. Reset overrides freeze.
- Latency: one cycle from ID-reg outputs to EXE/MEM outputs. Flag updates are visible on status_out the next cycle.
- freeze=1: EXE/MEM register and status register hold their values. Combinational branch outputs are unaffected.
- Val2 selection, first matching rule wins:
  - immidiate=1: zero-extended {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8]. A rotate of 0 means no rotation.
  - mem_read_enable or mem_write_enable: {20'b0, Shift_operand}.
  - Otherwise: Val_Rm shifted by Shift_operand[11:7] with type Shift_operand[6:5]. 00=LSL, 01=LSR, 10=ASR, 11=ROR. An amount of 0 means unshifted.
- exec_cmd results:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD (also LDR/STR address): Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-!C
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags unchanged.
- Flags:
  - N=result[31]; Z=(result==0).
  - Arithmetic: C = bit 32 of the 33-bit sum. For subtract, C = NOT borrow.
  - Add overflow: V=1 when operand signs are equal and the result sign differs.
  - Subtract overflow: V=1 when operand signs differ and the result sign differs from Rn.
  - Logic, MOV and MVN: C and V keep their prior values.
- Status register write: at posedge when S=1, freeze=0 and rst=0. If S=0, the register holds.
- Carry input: ADC/SBC read the current status register C, not the ID Status pipeline copy.
- branch_address: 32-bit wrap-around add, no overflow detection.
- Bubbles: an all-zero control word from the ID reg propagates as zeros. There is no separate valid bit.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: adds inputs sel_src1[1:0], sel_src2[1:0], mem_fwd_val[31:0] and wb_fwd_val[31:0].
  - sel=00 takes the ID-reg value, 01 takes mem_fwd_val, 10 takes wb_fwd_val, 11 is treated as 00.
  - sel_src1 replaces Val_Rn. sel_src2 replaces Val_Rm for both the shifter input and val_rm_out.
- Undefined: these ports do not exist and operands come straight from the ID reg.

Decomposition:
- Package exe_pkg holds:
  - exec_cmd localparams: CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR.
  - Shift-type constants: SH_LSL, SH_LSR, SH_ASR, SH_ROR.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module exe_alu: combinational, takes (cmd, a, b, cin) and returns (result, NZCV).
- Val2 generation, the status register and the EXE/MEM register stay in the top module.

Test Plan:
- rst=1 for 2 cycles, with non-zero inputs present -> all outputs 0 and status_out=0000.
- ADD, S=1: Rn=0x7FFFFFFF, immidiate=1, Shift_operand=0x001 -> next cycle alu_result=0x80000000, status_out=1001 (N=1, V=1).
- SUB/CMP, S=1: Rn=5, Val_Rm=5, Shift_operand=0x000 -> alu_result=0, status_out=0110 (Z=1, C=1).
- Immediate rotate: Shift_operand=0x4FF (rotate 8) with MOV -> alu_result=0xFF000000.
- Register shift: Shift_operand 5'd4/ASR on Val_Rm=0x80000000 -> 0xF8000000.
- Branch: branch_enable=1, PC=0x100, imm24=0xFFFFFE -> branch_address=0xF8.
- freeze=1 across an S=1 ADD -> outputs and status hold; after release, the new result is loaded on the next posedge.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared constants for the execute stage.
//   - exec_cmd encodings (CMD_*)
//   - shifter-operand shift types (SH_*)
//   - NZCV bit positions within the 4-bit status word (FLAG_*)
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational ALU of the execute stage.
// Ports:
//   cmd         in   4       exec_cmd encoding (see exe_pkg)
//   a, b        in   DATA_W  operand 1 (Rn) and operand 2 (Val2)
//   cin, vin    in   1       current status C and V
//   result      out  DATA_W  ALU result (0 for unknown commands)
//   nzcv        out  4       new flags {N,Z,C,V}
//   flags_valid out  1       0 for unknown commands (flags must not be written)
module exe_alu
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic              vin,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        nzcv,
    output logic              flags_valid
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic            c_new;
    logic            v_new;

    always_comb begin
        result      = '0;
        sum         = '0;
        c_new       = cin;   // logic ops and moves keep C and V
        v_new       = vin;
        flags_valid = 1'b1;
        case (cmd)
            CMD_MOV: result = b;
            CMD_MVN: result = ~b;
            CMD_ADD, CMD_ADC: begin
                sum    = {1'b0, a} + {1'b0, b}
                       + {{DATA_W{1'b0}}, (cmd == CMD_ADC) ? cin : 1'b0};
                result = sum[MSB:0];
                c_new  = sum[DATA_W];
                v_new  = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                // a - b - borrow as a + ~b + carry-in; bit 32 is NOT borrow
                sum    = {1'b0, a} + {1'b0, ~b}
                       + {{DATA_W{1'b0}}, (cmd == CMD_SBC) ? cin : 1'b1};
                result = sum[MSB:0];
                c_new  = sum[DATA_W];
                v_new  = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            CMD_AND: result = a & b;
            CMD_ORR: result = a | b;
            CMD_EOR: result = a ^ b;
            default: flags_valid = 1'b0;
        endcase
        nzcv         = '0;
        nzcv[FLAG_N] = result[MSB];
        nzcv[FLAG_Z] = (result == '0);
        nzcv[FLAG_C] = c_new;
        nzcv[FLAG_V] = v_new;
    end

endmodule

// File: rtl/exe_stage_unit.sv
// exe_stage_unit: execute stage of the 5-stage ARM-subset pipeline.
// Builds Val2 (immediate rotate / memory offset / register shift), runs the
// ALU, maintains the NZCV status register, computes the branch target and
// registers results into the EXE/MEM pipeline register.
// Ports:
//   clk, rst (sync, active-high), freeze (holds EXE/MEM reg and status)
//   ID-reg inputs: wb_enable, mem_read_enable, mem_write_enable,
//     branch_enable, S, exec_cmd, PC, Val_Rn, Val_Rm, immidiate,
//     Shift_operand, Signed_immidiate_24, Dest
//   Combinational: branch_taken, branch_address
//   status_out: status register {N,Z,C,V}
//   Registered: wb_en_out, mem_r_en_out, mem_w_en_out, alu_result,
//     val_rm_out, dest_out
// Build option: define FORWARDING_EN to add sel_src1, sel_src2,
//   mem_fwd_val and wb_fwd_val operand-forwarding inputs.
module exe_stage_unit
    import exe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  wb_enable,
    input  logic                  mem_read_enable,
    input  logic                  mem_write_enable,
    input  logic                  branch_enable,
    input  logic                  S,
    input  logic [3:0]            exec_cmd,
    input  logic [DATA_W-1:0]     PC,
    input  logic [DATA_W-1:0]     Val_Rn,
    input  logic [DATA_W-1:0]     Val_Rm,
    input  logic                  immidiate,
    input  logic [11:0]           Shift_operand,
    input  logic [23:0]           Signed_immidiate_24,
    input  logic [REG_ADDR_W-1:0] Dest,
`ifdef FORWARDING_EN
    input  logic [1:0]            sel_src1,
    input  logic [1:0]            sel_src2,
    input  logic [DATA_W-1:0]     mem_fwd_val,
    input  logic [DATA_W-1:0]     wb_fwd_val,
`endif
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     branch_address,
    output logic [3:0]            status_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic [REG_ADDR_W-1:0] dest_out
);

    // Rotate right; an amount of 0 leaves x unchanged (x << DATA_W is 0).
    function automatic logic [DATA_W-1:0] ror_word(input logic [DATA_W-1:0] x,
                                                   input logic [4:0]        amt);
        return (x >> amt) | (x << (6'(DATA_W) - {1'b0, amt}));
    endfunction

    logic [DATA_W-1:0]        op_rn;
    logic [DATA_W-1:0]        op_rm;
    logic signed [DATA_W-1:0] op_rm_s;
    logic [DATA_W-1:0]        val2;
    logic [4:0]               sh_amt;
    logic [DATA_W-1:0]        alu_res_p0;
    logic [3:0]               alu_nzcv_p0;
    logic                     alu_flags_vld_p0;

    logic [3:0]               status_p1;
    logic                     wb_en_p1;
    logic                     mem_r_en_p1;
    logic                     mem_w_en_p1;
    logic [DATA_W-1:0]        alu_result_p1;
    logic [DATA_W-1:0]        val_rm_p1;
    logic [REG_ADDR_W-1:0]    dest_p1;

`ifdef FORWARDING_EN
    always_comb begin
        case (sel_src1)
            2'b01:   op_rn = mem_fwd_val;
            2'b10:   op_rn = wb_fwd_val;
            default: op_rn = Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   op_rm = mem_fwd_val;
            2'b10:   op_rm = wb_fwd_val;
            default: op_rm = Val_Rm;
        endcase
    end
`else
    assign op_rn = Val_Rn;
    assign op_rm = Val_Rm;
`endif

    assign op_rm_s = op_rm;
    assign sh_amt  = Shift_operand[11:7];

    always_comb begin
        val2 = '0;
        if (immidiate) begin
            val2 = ror_word({{(DATA_W-8){1'b0}}, Shift_operand[7:0]},
                            {Shift_operand[11:8], 1'b0});
        end else if (mem_read_enable || mem_write_enable) begin
            val2 = {{(DATA_W-12){1'b0}}, Shift_operand};
        end else begin
            case (Shift_operand[6:5])
                SH_LSL:  val2 = op_rm << sh_amt;
                SH_LSR:  val2 = op_rm >> sh_amt;
                SH_ASR:  val2 = op_rm_s >>> sh_amt;
                default: val2 = ror_word(op_rm, sh_amt);
            endcase
        end
    end

    exe_alu #(.DATA_W(DATA_W)) u_alu (
        .cmd         (exec_cmd),
        .a           (op_rn),
        .b           (val2),
        .cin         (status_p1[FLAG_C]),
        .vin         (status_p1[FLAG_V]),
        .result      (alu_res_p0),
        .nzcv        (alu_nzcv_p0),
        .flags_valid (alu_flags_vld_p0)
    );

    assign branch_taken   = branch_enable;
    assign branch_address = PC + {{(DATA_W-26){Signed_immidiate_24[23]}},
                                  Signed_immidiate_24, 2'b00};

    // ---- p0 -> p1: EXE/MEM register and status register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            status_p1     <= '0;
            wb_en_p1      <= 1'b0;
            mem_r_en_p1   <= 1'b0;
            mem_w_en_p1   <= 1'b0;
            alu_result_p1 <= '0;
            val_rm_p1     <= '0;
            dest_p1       <= '0;
        end else if (!freeze) begin
            if (S && alu_flags_vld_p0)
                status_p1 <= alu_nzcv_p0;
            wb_en_p1      <= wb_enable;
            mem_r_en_p1   <= mem_read_enable;
            mem_w_en_p1   <= mem_write_enable;
            alu_result_p1 <= alu_res_p0;
            val_rm_p1     <= op_rm;
            dest_p1       <= Dest;
        end
    end

    assign status_out   = status_p1;
    assign wb_en_out    = wb_en_p1;
    assign mem_r_en_out = mem_r_en_p1;
    assign mem_w_en_out = mem_w_en_p1;
    assign alu_result   = alu_result_p1;
    assign val_rm_out   = val_rm_p1;
    assign dest_out     = dest_p1;

endmodule

// File: tb/tb_exe_stage_unit.sv
module tb_exe_stage_unit;

    logic        clk = 1'b0;
    logic        rst, freeze, wb_enable, mem_read_enable, mem_write_enable;
    logic        branch_enable, S, immidiate;
    logic [3:0]  exec_cmd, Dest;
    logic [31:0] PC, Val_Rn, Val_Rm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_immidiate_24;
    logic        branch_taken, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] branch_address, alu_result, val_rm_out;
    logic [3:0]  status_out, dest_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_stage_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_enable(wb_enable), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .branch_enable(branch_enable),
        .S(S), .exec_cmd(exec_cmd), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
        .immidiate(immidiate), .Shift_operand(Shift_operand),
        .Signed_immidiate_24(Signed_immidiate_24), .Dest(Dest),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .status_out(status_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_result(alu_result), .val_rm_out(val_rm_out), .dest_out(dest_out)
    );

    task automatic idle_inputs();
        freeze = 0; wb_enable = 0; mem_read_enable = 0; mem_write_enable = 0;
        branch_enable = 0; S = 0; immidiate = 0; exec_cmd = 4'h0; Dest = 4'h0;
        PC = 0; Val_Rn = 0; Val_Rm = 0; Shift_operand = 0; Signed_immidiate_24 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one ALU op (all other controls idle) and clock it in
    task automatic alu_op(input logic [3:0] cmd, input logic s, input logic imm,
                          input logic [31:0] rn, input logic [31:0] rm,
                          input logic [11:0] shop);
        idle_inputs();
        exec_cmd = cmd; S = s; immidiate = imm; Val_Rn = rn; Val_Rm = rm;
        Shift_operand = shop;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; wb_enable = 1; mem_read_enable = 1; mem_write_enable = 1; S = 1;
        exec_cmd = 4'b0010; Val_Rn = 32'h1234; Val_Rm = 32'h55; Dest = 4'hA;
        immidiate = 1; Shift_operand = 12'h0FF;
        step(); step();
        checks++;
        if ({wb_en_out, mem_r_en_out, mem_w_en_out} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {wb_en_out, mem_r_en_out, mem_w_en_out});
        end
        checks++;
        if (alu_result !== 32'h0 || val_rm_out !== 32'h0 || dest_out !== 4'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", alu_result, val_rm_out, dest_out);
        end
        checks++;
        if (status_out !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b expected 0000", status_out);
        end
        rst = 0;
    endtask

    task automatic test_add_overflow();
        idle_inputs();
        exec_cmd = 4'b0010; S = 1; Val_Rn = 32'h7FFFFFFF; immidiate = 1;
        Shift_operand = 12'h001; wb_enable = 1; Dest = 4'd3;
        step();
        checks++;
        if (alu_result !== 32'h80000000) begin
            errors++; $display("FAIL add_result: got %h expected 80000000", alu_result);
        end
        checks++;
        if (status_out !== 4'b1001) begin
            errors++; $display("FAIL add_flags: got %b expected 1001", status_out);
        end
        checks++;
        if (wb_en_out !== 1'b1 || dest_out !== 4'd3) begin
            errors++; $display("FAIL add_ctrl: got wb=%b dest=%h expected wb=1 dest=3", wb_en_out, dest_out);
        end
    endtask

    task automatic test_sub_and_carry();
        alu_op(4'b0100, 1, 0, 32'd5, 32'd5, 12'h000);
        checks++;
        if (alu_result !== 32'h0 || status_out !== 4'b0110) begin
            errors++; $display("FAIL sub_zero: got %h/%b expected 00000000/0110", alu_result, status_out);
        end
        // C=1 now: ADC adds it, S=0 keeps flags
        alu_op(4'b0011, 0, 0, 32'd1, 32'd2, 12'h000);
        checks++;
        if (alu_result !== 32'd4 || status_out !== 4'b0110) begin
            errors++; $display("FAIL adc_cin: got %h/%b expected 00000004/0110", alu_result, status_out);
        end
        // SBC with C=1 subtracts no extra borrow
        alu_op(4'b0101, 1, 0, 32'd10, 32'd3, 12'h000);
        checks++;
        if (alu_result !== 32'd7 || status_out !== 4'b0010) begin
            errors++; $display("FAIL sbc: got %h/%b expected 00000007/0010", alu_result, status_out);
        end
        // SBC with C=0 (after a borrowing SUB): 10-3-1
        alu_op(4'b0100, 1, 0, 32'd1, 32'd2, 12'h000);
        checks++;
        if (alu_result !== 32'hFFFFFFFF || status_out !== 4'b1000) begin
            errors++; $display("FAIL sub_borrow: got %h/%b expected ffffffff/1000", alu_result, status_out);
        end
        alu_op(4'b0101, 1, 0, 32'd10, 32'd3, 12'h000);
        checks++;
        if (alu_result !== 32'd6 || status_out !== 4'b0010) begin
            errors++; $display("FAIL sbc_borrow: got %h/%b expected 00000006/0010", alu_result, status_out);
        end
    endtask

    task automatic test_imm_rotate();
        alu_op(4'b0001, 1, 1, 32'h0, 32'h0, 12'h4FF);
        checks++;
        if (alu_result !== 32'hFF000000 || status_out !== 4'b1010) begin
            errors++; $display("FAIL imm_rotate: got %h/%b expected ff000000/1010", alu_result, status_out);
        end
        alu_op(4'b1001, 0, 1, 32'h0, 32'h0, 12'h000);
        checks++;
        if (alu_result !== 32'hFFFFFFFF || status_out !== 4'b1010) begin
            errors++; $display("FAIL mvn: got %h/%b expected ffffffff/1010", alu_result, status_out);
        end
    endtask

    task automatic test_reg_shift();
        logic [31:0] vin  [4] = '{32'h80000000, 32'h80000000, 32'h80000001, 32'h80000001};
        logic [11:0] shop [4] = '{12'h240, 12'h220, 12'h260, 12'h080};
        logic [31:0] exp  [4] = '{32'hF8000000, 32'h08000000, 32'h18000000, 32'h00000002};
        for (int i = 0; i < 4; i++) begin
            alu_op(4'b0001, 0, 0, 32'h0, vin[i], shop[i]);
            checks++;
            if (alu_result !== exp[i]) begin
                errors++; $display("FAIL reg_shift[%0d]: got %h expected %h", i, alu_result, exp[i]);
            end
        end
    endtask

    task automatic test_logic();
        alu_op(4'b0110, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000);
        checks++;
        if (alu_result !== 32'hF000F000) begin
            errors++; $display("FAIL and: got %h expected f000f000", alu_result);
        end
        alu_op(4'b0111, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000);
        checks++;
        if (alu_result !== 32'hFFF0FFF0) begin
            errors++; $display("FAIL orr: got %h expected fff0fff0", alu_result);
        end
        alu_op(4'b1000, 1, 0, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000);
        checks++;
        if (alu_result !== 32'h0FF00FF0 || status_out !== 4'b0010) begin
            errors++; $display("FAIL eor: got %h/%b expected 0ff00ff0/0010", alu_result, status_out);
        end
        // unknown command: result 0, flags untouched even with S=1
        alu_op(4'b0000, 1, 0, 32'h1, 32'h1, 12'h000);
        checks++;
        if (alu_result !== 32'h0 || status_out !== 4'b0010) begin
            errors++; $display("FAIL bad_cmd: got %h/%b expected 00000000/0010", alu_result, status_out);
        end
    endtask

    task automatic test_mem_offset();
        idle_inputs();
        exec_cmd = 4'b0010; mem_write_enable = 1; Val_Rn = 32'h1000;
        Val_Rm = 32'hDEADBEEF; Shift_operand = 12'h123;
        step();
        checks++;
        if (alu_result !== 32'h1123 || val_rm_out !== 32'hDEADBEEF || mem_w_en_out !== 1'b1 || mem_r_en_out !== 1'b0) begin
            errors++; $display("FAIL str_addr: got %h/%h/w%b/r%b expected 00001123/deadbeef/w1/r0", alu_result, val_rm_out, mem_w_en_out, mem_r_en_out);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        branch_enable = 1; PC = 32'h100; Signed_immidiate_24 = 24'hFFFFFE;
        #1;
        checks++;
        if (branch_taken !== 1'b1 || branch_address !== 32'h000000F8) begin
            errors++; $display("FAIL branch: got %b/%h expected 1/000000f8", branch_taken, branch_address);
        end
        Signed_immidiate_24 = 24'h000010;
        #1;
        checks++;
        if (branch_address !== 32'h00000140) begin
            errors++; $display("FAIL branch_fwd: got %h expected 00000140", branch_address);
        end
        step();
    endtask

    task automatic test_freeze();
        alu_op(4'b0010, 1, 1, 32'h7FFFFFFF, 32'h0, 12'h001);
        idle_inputs();
        freeze = 1; exec_cmd = 4'b0010; S = 1; immidiate = 1; Val_Rn = 32'hFFFFFFFF;
        Shift_operand = 12'h001; wb_enable = 1; Dest = 4'd7;
        step(); step();
        checks++;
        if (alu_result !== 32'h80000000 || status_out !== 4'b1001 || dest_out !== 4'd0) begin
            errors++; $display("FAIL freeze_hold: got %h/%b/%h expected 80000000/1001/0", alu_result, status_out, dest_out);
        end
        freeze = 0;
        step();
        checks++;
        if (alu_result !== 32'h0 || status_out !== 4'b0110 || dest_out !== 4'd7) begin
            errors++; $display("FAIL freeze_release: got %h/%b/%h expected 00000000/0110/7", alu_result, status_out, dest_out);
        end
    endtask

    task automatic test_bubble_and_reset_freeze();
        idle_inputs();
        step();
        checks++;
        if ({wb_en_out, mem_r_en_out, mem_w_en_out} !== 3'b000 || alu_result !== 32'h0 || dest_out !== 4'h0 || status_out !== 4'b0110) begin
            errors++; $display("FAIL bubble: got %b/%h/%h/%b expected 000/0/0/0110", {wb_en_out, mem_r_en_out, mem_w_en_out}, alu_result, dest_out, status_out);
        end
        alu_op(4'b0001, 0, 0, 32'h0, 32'h1234, 12'h000);
        idle_inputs();
        rst = 1; freeze = 1;
        step();
        rst = 0; freeze = 0;
        checks++;
        if (alu_result !== 32'h0 || status_out !== 4'b0000) begin
            errors++; $display("FAIL reset_over_freeze: got %h/%b expected 00000000/0000", alu_result, status_out);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_add_overflow();
        test_sub_and_carry();
        test_imm_rotate();
        test_reg_shift();
        test_logic();
        test_mem_offset();
        test_branch();
        test_freeze();
        test_bubble_and_reset_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
